// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: board-clock reset sequencer.
// Merges PLL lock, the debounced reset button and a software reset pulse into one
// fault term, then releases NumDomains active-low resets one at a time in index
// order after a fault-free hold period.
// Optional feature: define RST_SEQ_CAUSE_EN to record the cause of the last reset
// entry on cause_o. Without it, cause_o is tied low and cause_clr_i is ignored.
module rst_seq_ctrl #(
    parameter int NumDomains     = 3,
    parameter int HoldCycles     = 255,
    parameter int StepCycles     = 16,
    parameter int DebounceCycles = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_locked_i,
    input  logic                  rst_btn_i,
    input  logic                  sw_rst_req_i,
    output logic [NumDomains-1:0] rst_no,
    output logic                  all_released_o,
    output logic [3:0]            cause_o,
    input  logic                  cause_clr_i
);

    // One counter width serves the hold, step and debounce counters.
    localparam int MaxHoldStep = (HoldCycles > StepCycles) ? HoldCycles : StepCycles;
    localparam int MaxCycles   = (MaxHoldStep > DebounceCycles) ? MaxHoldStep : DebounceCycles;
    localparam int CntW        = $clog2(MaxCycles + 1);
    localparam int IdxW        = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] StepLast = CntW'(StepCycles - 1);
    localparam logic [CntW-1:0] DbLast   = CntW'(DebounceCycles - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumDomains - 1);

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_t;

    logic                  r_pllMeta;
    logic                  r_pllSync;
    logic                  r_btnMeta;
    logic                  r_btnSync;
    logic                  r_btnStable;
    logic [CntW-1:0]       r_dbCnt;
    state_t                r_state;
    logic [CntW-1:0]       r_cnt;
    logic [IdxW-1:0]       r_idx;
    logic [NumDomains-1:0] r_rstN;
    logic                  r_allReleased;

    state_t                w_nextState;
    logic [CntW-1:0]       w_nextCnt;
    logic [IdxW-1:0]       w_nextIdx;
    logic [NumDomains-1:0] w_nextRstN;
    logic                  w_nextAll;
    logic                  w_causeLoad;
    logic                  w_fault;

    // Two-flop synchronisers for the asynchronous PLL lock and button inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pllMeta <= 1'b0;
            r_pllSync <= 1'b0;
            r_btnMeta <= 1'b0;
            r_btnSync <= 1'b0;
        end else begin
            r_pllMeta <= pll_locked_i;
            r_pllSync <= r_pllMeta;
            r_btnMeta <= rst_btn_i;
            r_btnSync <= r_btnMeta;
        end
    end

    // Button debounce: a new synced level is accepted only after it persists DebounceCycles cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dbCnt     <= '0;
            r_btnStable <= 1'b0;
        end else if (r_btnSync != r_btnStable) begin
            if (r_dbCnt == DbLast) begin
                r_btnStable <= r_btnSync;
                r_dbCnt     <= '0;
            end else begin
                r_dbCnt <= r_dbCnt + CntW'(1);
            end
        end else begin
            r_dbCnt <= '0;
        end
    end

    assign w_fault = ~r_pllSync | r_btnStable | sw_rst_req_i;

    // Sequencer state, counters and the registered reset outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= StHold;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_rstN        <= '0;
            r_allReleased <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_cnt         <= w_nextCnt;
            r_idx         <= w_nextIdx;
            r_rstN        <= w_nextRstN;
            r_allReleased <= w_nextAll;
        end
    end

    // Next-state logic: a fault always wins over a release due in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_nextRstN  = r_rstN;
        w_nextAll   = r_allReleased;
        w_causeLoad = 1'b0;
        case (r_state)
            StHold: begin
                w_nextRstN = '0;
                w_nextAll  = 1'b0;
                if (w_fault) begin
                    w_nextCnt = '0;
                end else if (r_cnt == HoldLast) begin
                    w_nextState = StRelease;
                    w_nextCnt   = '0;
                    w_nextIdx   = '0;
                end else begin
                    w_nextCnt = r_cnt + CntW'(1);
                end
            end
            StRelease: begin
                if (w_fault) begin
                    w_nextState = StHold;
                    w_nextCnt   = '0;
                    w_nextIdx   = '0;
                    w_nextRstN  = '0;
                    w_nextAll   = 1'b0;
                    w_causeLoad = 1'b1;
                end else if (r_cnt == StepLast) begin
                    w_nextRstN[r_idx] = 1'b1;
                    w_nextCnt         = '0;
                    if (r_idx == LastIdx) begin
                        w_nextState = StRun;
                        w_nextAll   = 1'b1;
                    end else begin
                        w_nextIdx = r_idx + IdxW'(1);
                    end
                end else begin
                    w_nextCnt = r_cnt + CntW'(1);
                end
            end
            StRun: begin
                if (w_fault) begin
                    w_nextState = StHold;
                    w_nextCnt   = '0;
                    w_nextIdx   = '0;
                    w_nextRstN  = '0;
                    w_nextAll   = 1'b0;
                    w_causeLoad = 1'b1;
                end else begin
                    w_nextRstN = '1;
                    w_nextAll  = 1'b1;
                end
            end
            default: begin
                w_nextState = StHold;
                w_nextCnt   = '0;
                w_nextIdx   = '0;
                w_nextRstN  = '0;
                w_nextAll   = 1'b0;
            end
        endcase
    end

    assign rst_no         = r_rstN;
    assign all_released_o = r_allReleased;

`ifdef RST_SEQ_CAUSE_EN
    logic [3:0] r_cause;

    // Cause capture: a new reset entry overrides a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cause <= 4'b0001;
        end else if (w_causeLoad) begin
            r_cause <= {sw_rst_req_i, ~r_pllSync, r_btnStable, 1'b0};
        end else if (cause_clr_i) begin
            r_cause <= 4'b0000;
        end
    end

    assign cause_o = r_cause;
`else
    logic w_unused;

    assign cause_o  = 4'b0000;
    assign w_unused = &{1'b0, cause_clr_i, w_causeLoad};
`endif

endmodule
